feed_forward: RTL and testbench
===============================

Name: feed_forward

Overview:
- Fixed-point multilayer-perceptron inference engine with four layers: an input layer, two hidden layers and an output layer.
- Layer sizes are run-time inputs.
- The input vector, weights and biases are streamed in one 32-bit word per clock after a load pulse. A start pulse runs the forward pass.
- Output neuron values are streamed out, one per cycle, under the oldu ("done") strobe.
- The block sits behind the sensor-feature front end of the e-nose classifier.

Parameters:
- DEPTH, 256, capacity of the internal parameter/data word memory.
- FRAC, 16, fractional bits of the signed fixed-point format (Q16.16).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- data  in  32  streamed word: input value, weight or bias, signed Q16.16.
- load  in  1  one-cycle pulse that starts a load session.
- start  in  1  one-cycle pulse that starts inference.
- first_layer  in  4  input-layer size L1 (1..15).
- second_layer  in  4  hidden-layer-1 size L2.
- third_layer  in  4  hidden-layer-2 size L3.
- fourth_layer  in  4  output-layer size L4.
- oldu  out  1  high while output values are presented.
- data_out  out  32  output neuron value, Q16.16.

Behaviour:
- Reset (rst=0, async): state IDLE, oldu=0, data_out=0, load counter=0, loaded flag=0. Memory contents are not reset.
- States: IDLE, LOAD, RUN, EMIT.
- IDLE -> LOAD on load=1:
  - L1..L4 are sampled in that cycle and held until the next load.
  - The expected word count is N = L1 + (L1+1)*L2 + (L2+1)*L3 + (L3+1)*L4.
- LOAD: one data word is captured on each clock starting the cycle after the load pulse. There is no valid signal.
- Word order:
  - L1 input values.
  - For each hidden-1 neuron j: L1 weights (in input order), then bias.
  - The same pattern for hidden-2 (L2 weights + bias), then for the output layer (L3 weights + bias).
- After N words: loaded flag=1, return to IDLE. Words beyond N are ignored.
- If N > DEPTH or any layer size is 0: the load session ends with loaded=0.
- load=1 in any non-reset state aborts the current activity and begins a new load session. oldu drops immediately.
- start=1 in IDLE with loaded=1 -> RUN. start is ignored in every other state or when loaded=0.
- RUN, per neuron:
  - Accumulator clears to 0.
  - One MAC per clock: product = a*w as a 64-bit signed value, arithmetic shift right by FRAC (truncate toward -inf), added into the accumulator.
  - Bias is added after the last MAC.
  - The result is saturated to the signed 32-bit range (0x7FFFFFFF / 0x80000000). Saturation is applied after each addition.
- Activation:
  - Hidden layers use ReLU (negative -> 0).
  - Output layer is linear.
- Hidden activations are stored internally. Input words in memory are not modified, so start may be repeated without reloading and gives identical results.
- RUN latency: at most sum over layers of L_out*(L_in+2), plus 4 cycles, from the start pulse to the first oldu cycle.
- EMIT:
  - oldu=1 for exactly L4 consecutive cycles.
  - data_out = y[k] on the k-th cycle (k = 0..L4-1).
  - Then oldu=0, state IDLE, data_out holds y[L4-1].
- start during RUN/EMIT is ignored.
- Layer-size inputs changing outside the load pulse cycle have no effect.

Test Plan:
- Chain with sizes 1,1,1,1; load, then 7 words:
  - 0x00020000 (x=2.0); 0x00018000, 0x00008000 (w=1.5, b=0.5 -> 3.5); 0x00010000, 0x0 (-> 3.5); 0xFFFE0000, 0x00010000 (w=-2.0, b=1.0).
  - Start -> oldu high 1 cycle, data_out=0xFFFA0000 (-6.0).
- ReLU: same setup but first weight 0xFFFF0000 (-1.0):
  - Hidden-1 = -1.5 clipped to 0 -> data_out=0x00010000.
- Sizes 4,6,5,3: load 92 words.
  - All weights 0; output biases 1.0, 2.0, -3.0; other words 0.
  - Expected: N=87, last 5 words ignored. oldu high exactly 3 cycles with data_out 0x00010000, 0x00020000, 0xFFFD0000. Done within latency bound.
- Saturation, sizes 1,1,1,1:
  - x=0x7FFF0000, w1=0x00020000 -> hidden-1 = 0x7FFFFFFF.
  - Then w=1.0, b=0 for the remaining layers -> data_out=0x7FFFFFFF.
- Control:
  - start before any load -> oldu stays 0.
  - Repeat start after a completed run -> identical output.
  - rst low mid-RUN -> oldu=0 and data_out=0 immediately; a subsequent start without reload is ignored.
  - load during EMIT -> oldu drops next cycle.

Source files
------------

// File: rtl/feed_forward_if.sv
// feed_forward_if: streamed load/start/size inputs and emitted results of the MLP engine
interface feed_forward_if;
  logic [31:0] data;
  logic load;
  logic start;
  logic [3:0] first_layer;
  logic [3:0] second_layer;
  logic [3:0] third_layer;
  logic [3:0] fourth_layer;
  logic oldu;
  logic [31:0] data_out;
  modport master (output data, load, start, first_layer, second_layer, third_layer, fourth_layer, input oldu, data_out);
  modport slave (input data, load, start, first_layer, second_layer, third_layer, fourth_layer, output oldu, data_out);
endinterface

// File: rtl/feed_forward.sv
// feed_forward: Q16.16 four-layer MLP inference engine with streamed load and emitted outputs
module feed_forward #(
  parameter int DEPTH = 256,
  parameter int FRAC = 16
) (
  input logic clk,
  input logic rst,
  feed_forward_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, EMIT = 2'd3;
  logic [1:0] st, lyr;
  logic [3:0] l1, l2, l3, l4, i, j, k, n_in, n_out;
  logic [15:0] n, n_c, cnt;
  logic [AW-1:0] p;
  logic bad, loaded, last_in;
  logic signed [31:0] acc, a, w, sat, res;
  logic signed [63:0] prod, term, sum;
  logic [31:0] mem [DEPTH];
  logic [31:0] h1 [16];
  logic [31:0] h2 [16];
  logic [31:0] y [16];
  assign n_c = 16'(bus.first_layer) + (16'(bus.first_layer) + 16'd1) * 16'(bus.second_layer)
             + (16'(bus.second_layer) + 16'd1) * 16'(bus.third_layer)
             + (16'(bus.third_layer) + 16'd1) * 16'(bus.fourth_layer);
  assign n_in = lyr == 2'd0 ? l1 : lyr == 2'd1 ? l2 : l3;
  assign n_out = lyr == 2'd0 ? l2 : lyr == 2'd1 ? l3 : l4;
  assign a = lyr == 2'd0 ? mem[AW'(i)] : lyr == 2'd1 ? h1[i] : h2[i];
  // weights and biases of all layers are contiguous, so one pointer walks them in order
  assign w = mem[p];
  assign last_in = i == n_in;
  assign prod = 64'(a) * 64'(w);
  assign term = last_in ? 64'(w) : prod >>> FRAC;
  assign sum = 64'(acc) + term;
  assign sat = (&sum[63:31] || ~|sum[63:31]) ? sum[31:0] : sum[63] ? 32'sh80000000 : 32'sh7FFFFFFF;
  assign res = (lyr != 2'd2 && sat[31]) ? '0 : sat;
  always_ff @(posedge clk) begin
    if (st == LOAD && !bad && !bus.load) mem[cnt[AW-1:0]] <= bus.data;
    if (st == RUN && last_in && !bus.load) begin
      if (lyr == 2'd0) h1[j] <= res;
      else if (lyr == 2'd1) h2[j] <= res;
      else y[j] <= res;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= IDLE;
      lyr <= '0;
      {l1, l2, l3, l4, i, j, k} <= '0;
      n <= '0;
      cnt <= '0;
      p <= '0;
      bad <= 1'b0;
      loaded <= 1'b0;
      acc <= '0;
      bus.oldu <= 1'b0;
      bus.data_out <= '0;
    end else if (bus.load) begin
      st <= LOAD;
      {l1, l2, l3, l4} <= {bus.first_layer, bus.second_layer, bus.third_layer, bus.fourth_layer};
      n <= n_c;
      bad <= n_c > 16'(DEPTH) || bus.first_layer == '0 || bus.second_layer == '0
             || bus.third_layer == '0 || bus.fourth_layer == '0;
      cnt <= '0;
      loaded <= 1'b0;
      bus.oldu <= 1'b0;
    end else begin
      case (st)
        IDLE: if (bus.start && loaded) begin
          st <= RUN;
          lyr <= '0;
          {i, j} <= '0;
          acc <= '0;
          p <= AW'(l1);
        end
        LOAD: if (bad) st <= IDLE;
        else begin
          cnt <= cnt + 16'd1;
          if (cnt == n - 16'd1) begin
            loaded <= 1'b1;
            st <= IDLE;
          end
        end
        RUN: begin
          p <= p + 1'b1;
          if (!last_in) begin
            acc <= sat;
            i <= i + 4'd1;
          end else begin
            acc <= '0;
            i <= '0;
            j <= j == n_out - 4'd1 ? '0 : j + 4'd1;
            if (j == n_out - 4'd1) begin
              lyr <= lyr + 2'd1;
              k <= '0;
              if (lyr == 2'd2) st <= EMIT;
            end
          end
        end
        default: if (k == l4) begin
          bus.oldu <= 1'b0;
          st <= IDLE;
        end else begin
          bus.oldu <= 1'b1;
          bus.data_out <= y[k];
          k <= k + 4'd1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_feed_forward.sv
// tb_feed_forward: directed and randomized checks of feed_forward against a queue-based MLP model
module tb_feed_forward;
  localparam longint MX = 64'sh7FFFFFFF;
  localparam longint MN = -64'sh80000000;
  logic clk, rst;
  feed_forward_if ffi ();
  feed_forward dut (.clk(clk), .rst(rst), .bus(ffi));
  int sz[4];
  logic [31:0] words[$], expq[$];
  int checks = 0, passes = 0;
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, got, want);
  endtask
  function automatic longint satf(longint v);
    return v > MX ? MX : v < MN ? MN : v;
  endfunction
  function automatic int bound_f();
    return sz[1] * (sz[0] + 2) + sz[2] * (sz[1] + 2) + sz[3] * (sz[2] + 2) + 4;
  endfunction
  function automatic int n_words();
    return sz[0] + (sz[0] + 1) * sz[1] + (sz[1] + 1) * sz[2] + (sz[2] + 1) * sz[3];
  endfunction
  task automatic compute();
    longint act[$], nxt[$], acc;
    int p;
    act = {};
    for (int i = 0; i < sz[0]; i++) act.push_back(longint'($signed(words[i])));
    p = sz[0];
    for (int l = 1; l < 4; l++) begin
      nxt = {};
      for (int j = 0; j < sz[l]; j++) begin
        acc = 0;
        for (int i = 0; i < sz[l-1]; i++) begin
          acc = satf(acc + ((act[i] * longint'($signed(words[p]))) >>> 16));
          p++;
        end
        acc = satf(acc + longint'($signed(words[p])));
        p++;
        if (l < 3 && acc < 0) acc = 0;
        nxt.push_back(acc);
      end
      act = nxt;
    end
    expq = {};
    foreach (act[i]) expq.push_back(32'(act[i]));
  endtask
  task automatic load_words();
    @(negedge clk);
    ffi.load = 1;
    ffi.first_layer = 4'(sz[0]);
    ffi.second_layer = 4'(sz[1]);
    ffi.third_layer = 4'(sz[2]);
    ffi.fourth_layer = 4'(sz[3]);
    @(negedge clk);
    ffi.load = 0;
    {ffi.first_layer, ffi.second_layer, ffi.third_layer, ffi.fourth_layer} = 16'($urandom);
    foreach (words[i]) begin
      ffi.data = words[i];
      @(negedge clk);
    end
    ffi.data = 32'($urandom);
    repeat (2) @(negedge clk);
  endtask
  task automatic run_check(input string tag);
    int cyc;
    @(negedge clk) ffi.start = 1;
    @(negedge clk) ffi.start = 0;
    cyc = 1;
    while (!ffi.oldu && cyc < bound_f()) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, 32'(ffi.oldu), 32'd1);
    if (ffi.oldu) begin
      foreach (expq[k]) begin
        chk({tag, "_oldu"}, 32'(ffi.oldu), 32'd1);
        chk($sformatf("%s_y%0d", tag, k), ffi.data_out, expq[k]);
        @(negedge clk);
      end
      chk({tag, "_end"}, 32'(ffi.oldu), 32'd0);
      chk({tag, "_hold"}, ffi.data_out, expq[expq.size()-1]);
    end
  endtask
  task automatic no_output(input string tag, input int n);
    logic seen;
    seen = 0;
    @(negedge clk) ffi.start = 1;
    @(negedge clk) ffi.start = 0;
    repeat (n) begin
      if (ffi.oldu) seen = 1;
      @(negedge clk);
    end
    chk(tag, 32'(seen), 32'd0);
  endtask
  task automatic big_words();
    sz = '{4, 6, 5, 3};
    words = {};
    repeat (87) words.push_back(32'd0);
    repeat (5) words.push_back(32'h7FFF0000);
    words[74] = 32'h00010000;
    words[80] = 32'h00020000;
    words[86] = 32'hFFFD0000;
    expq = '{32'h00010000, 32'h00020000, 32'hFFFD0000};
  endtask
  task automatic rand_test(input bit big);
    foreach (sz[d]) sz[d] = $urandom_range(1, 5);
    words = {};
    repeat (n_words()) words.push_back(big ? 32'($urandom) : 32'($urandom_range(0, 32'h60000)) - 32'h30000);
    compute();
    load_words();
    run_check(big ? "rand_big" : "rand");
  endtask
  initial begin
    int cyc;
    clk = 0;
    rst = 0;
    ffi.load = 0;
    ffi.start = 0;
    ffi.data = 0;
    {ffi.first_layer, ffi.second_layer, ffi.third_layer, ffi.fourth_layer} = '0;
    repeat (3) @(negedge clk);
    chk("rst_oldu", 32'(ffi.oldu), 32'd0);
    chk("rst_dout", ffi.data_out, 32'd0);
    rst = 1;
    no_output("start_unloaded", 20);
    sz = '{1, 1, 1, 1};
    words = '{32'h00020000, 32'h00018000, 32'h00008000, 32'h00010000, 32'h0, 32'hFFFE0000, 32'h00010000};
    load_words();
    expq = '{32'hFFFA0000};
    run_check("chain");
    run_check("repeat");
    words[1] = 32'hFFFF0000;
    load_words();
    expq = '{32'h00010000};
    run_check("relu");
    big_words();
    load_words();
    run_check("sizes4653");
    words = '{32'h7FFF0000, 32'h00020000, 32'h0, 32'h00010000, 32'h0, 32'h00010000, 32'h0};
    sz = '{1, 1, 1, 1};
    load_words();
    expq = '{32'h7FFFFFFF};
    run_check("saturate");
    sz = '{15, 15, 15, 15};
    words = {};
    repeat (10) words.push_back(32'($urandom));
    load_words();
    no_output("oversize", 60);
    sz = '{2, 0, 1, 1};
    words = '{32'h10000, 32'h10000, 32'h10000, 32'h10000, 32'h10000};
    load_words();
    no_output("zero_layer", 40);
    repeat (6) rand_test(0);
    repeat (3) rand_test(1);
    sz = '{1, 1, 1, 4};
    words = {};
    repeat (n_words()) words.push_back(32'($urandom_range(0, 32'h40000)));
    load_words();
    @(negedge clk) ffi.start = 1;
    @(negedge clk) ffi.start = 0;
    cyc = 1;
    while (!ffi.oldu && cyc < bound_f()) begin
      @(negedge clk);
      cyc++;
    end
    chk("emit_seen", 32'(ffi.oldu), 32'd1);
    ffi.load = 1;
    @(negedge clk) ffi.load = 0;
    chk("load_abort", 32'(ffi.oldu), 32'd0);
    big_words();
    load_words();
    run_check("pre_reset");
    @(negedge clk) ffi.start = 1;
    @(negedge clk) ffi.start = 0;
    repeat (10) @(negedge clk);
    rst = 0;
    #1;
    chk("rst_run_oldu", 32'(ffi.oldu), 32'd0);
    chk("rst_run_dout", ffi.data_out, 32'd0);
    @(negedge clk) rst = 1;
    no_output("start_after_rst", 120);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
